// File: rtl/enc_round_pipe.sv
// Pipelined rotate/add cipher with one round per register stage and per-stage valid/ready flow control.
// Each beat carries its own key and mode; decrypt runs the rounds in reverse order.
module enc_round_pipe #(
   parameter int DATA_W = 16,
   parameter int KEY_W  = 3,
   parameter int ROUNDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEY_W-1:0]  in_key,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_mode,
   output logic              busy
);

   localparam int SH_W = $clog2(DATA_W);

   logic [ROUNDS-1:0] st_vld;
   logic [ROUNDS-1:0] st_mode;
   logic [DATA_W-1:0] st_data [ROUNDS];
   logic [KEY_W-1:0]  st_key  [ROUNDS];

   logic [ROUNDS-1:0] can_load;
   logic [ROUNDS-1:0] load;
   logic [ROUNDS-1:0] src_vld;
   logic [ROUNDS-1:0] src_mode;
   logic [DATA_W-1:0] src_data [ROUNDS];
   logic [KEY_W-1:0]  src_key  [ROUNDS];
   logic [DATA_W-1:0] nxt_data [ROUNDS];

   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input logic [SH_W-1:0] s);
      logic [2*DATA_W-1:0] t;
      t = {x, x} << s;
      return t[2*DATA_W-1:DATA_W];
   endfunction

   function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input logic [SH_W-1:0] s);
      logic [2*DATA_W-1:0] t;
      t = {x, x} >> s;
      return t[DATA_W-1:0];
   endfunction

   // Stage j runs round j when encrypting and round ROUNDS-1-j when decrypting.
   function automatic logic [DATA_W-1:0] round_fn(input logic [DATA_W-1:0] x,
                                                  input logic [KEY_W-1:0]  k,
                                                  input logic              m,
                                                  input int                stage);
      int                r;
      logic [KEY_W-1:0]  kr;
      logic [SH_W-1:0]   sh;
      logic [DATA_W-1:0] kx;
      r  = m ? (ROUNDS - 1 - stage) : stage;
      kr = k + KEY_W'(r);
      sh = SH_W'(kr);
      kx = DATA_W'(kr);
      if (!m) return rotl(x, sh) + kx;
      else    return rotr(x - kx, sh);
   endfunction

   // NOTE: every variable gets a full default before the loops so no latch is inferred.
   always_comb begin
      can_load = '0;
      src_vld  = '0;
      src_mode = '0;
      for (int i = 0; i < ROUNDS; i++) begin
         src_data[i] = '0;
         src_key[i]  = '0;
      end

      // A stage can take a new beat when empty or when its own beat moves on.
      can_load[ROUNDS-1] = !st_vld[ROUNDS-1] || out_ready;
      for (int i = ROUNDS - 2; i >= 0; i--)
         can_load[i] = !st_vld[i] || can_load[i+1];

      src_vld[0]  = in_valid;
      src_mode[0] = in_mode;
      src_data[0] = in_data;
      src_key[0]  = in_key;
      for (int i = 1; i < ROUNDS; i++) begin
         src_vld[i]  = st_vld[i-1];
         src_mode[i] = st_mode[i-1];
         src_data[i] = st_data[i-1];
         src_key[i]  = st_key[i-1];
      end

      load = src_vld & can_load;
      for (int i = 0; i < ROUNDS; i++)
         nxt_data[i] = round_fn(src_data[i], src_key[i], src_mode[i], i);
   end

   // NOTE: the data/key arrays are reset too, so out_data reads zero during and after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_vld  <= '0;
         st_mode <= '0;
         for (int i = 0; i < ROUNDS; i++) begin
            st_data[i] <= '0;
            st_key[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < ROUNDS; i++) begin
            if (can_load[i])
               st_vld[i] <= src_vld[i];
            if (load[i]) begin
               st_data[i] <= nxt_data[i];
               st_key[i]  <= src_key[i];
               st_mode[i] <= src_mode[i];
            end
         end
      end
   end

   assign in_ready  = can_load[0];
   assign out_valid = st_vld[ROUNDS-1];
   assign out_data  = st_data[ROUNDS-1];
   assign out_mode  = st_mode[ROUNDS-1];
   assign busy      = |st_vld;

endmodule

// File: doc/enc_round_pipe.md
ENC_ROUND_PIPE -- requirements
Module: enc_round_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width; power of two, 8..64.
REQ-002 SHALL have parameter KEY_W, default 3, key width; 1..log2(DATA_W)+4.
REQ-003 SHALL have parameter ROUNDS, default 4, number of round stages (pipeline depth); 1..16.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  beat offered on in_data/in_key/in_mode.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 in_data  input  DATA_W  plaintext (encrypt) or ciphertext (decrypt).
REQ-009 in_key  input  KEY_W  per-beat base key.
REQ-010 in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-011 out_valid  output  1  result beat present on out_data/out_mode.
REQ-012 out_ready  input  1  downstream accepts result beat.
REQ-013 out_data  output  DATA_W  result.
REQ-014 out_mode  output  1  mode the result beat was accepted with.
REQ-015 busy  output  1  high when any stage holds a valid beat.

Function
REQ-016 Beat accepted when in_valid && in_ready; delivered when out_valid && out_ready.
REQ-017 Pipeline SHALL have ROUNDS register stages, each holding valid bit, data, key, mode; stage ROUNDS-1 drives out_*.
REQ-018 Stage ROUNDS-1 advances when out_ready; stage i<ROUNDS-1 advances when valid and stage i+1 can load; stage can load when empty or advancing; in_ready = stage 0 can load.
REQ-019 A stalled stage SHALL hold data, key and mode unchanged; no beat dropped or duplicated; out_data stable while out_valid && !out_ready.
REQ-020 Throughput one beat per cycle with out_ready high; latency ROUNDS cycles from accept edge to out_valid.
REQ-021 Round key k_r = (in_key + r) mod 2^KEY_W, r = 0..ROUNDS-1; shift s_r = k_r mod DATA_W; k_r zero-extended for arithmetic.
REQ-022 Encrypt: stage j applies round r=j: x = rotl(x, s_r) + k_r mod 2^DATA_W.
REQ-023 Decrypt: stage j applies round r=ROUNDS-1-j: x = rotr(x - k_r mod 2^DATA_W, s_r).
REQ-024 Decrypt of encrypt output with same key SHALL return original data exactly, all DATA_W/KEY_W/ROUNDS.
REQ-025 Beats with different keys and modes SHALL interleave freely back-to-back; each beat uses only its own key and mode.
REQ-026 Simultaneous accept and deliver with full pipeline and out_ready high SHALL sustain full rate.
REQ-027 in_ready SHALL depend on out_ready combinationally; in_valid SHALL NOT affect in_ready.

Reset
REQ-028 On rst: all stage valid bits 0, data/key/mode registers 0; out_valid=0, out_data=0, out_mode=0, busy=0.
REQ-029 rst mid-operation SHALL discard all in-flight beats; none emerge after release.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).

Verification (DATA_W=16, KEY_W=3, ROUNDS=4)
REQ-031 Encrypt in_data=0x0001, key=0 -> out_data=0x0073, out_mode=0, out_valid 4 cycles after accept.
REQ-032 Decrypt in_data=0x0073, key=0 -> out_data=0x0001; encrypt 0xFFFF key=1 -> 0x0134 (addition wrap in round 0).
REQ-033 Key wrap: key=7 round keys 7,0,1,2; random data enc then dec with key=7 -> original returned.
REQ-034 Back-to-back 16 mixed enc/dec beats, out_ready toggled pseudo-randomly -> order preserved, values match model, no loss/duplication, out_data stable while stalled.
REQ-035 Fill pipeline (4 beats), hold out_ready=0 -> in_ready=0 after 4 accepts, busy=1; release -> one beat/cycle, in_ready=1 same cycle.
REQ-036 Assert rst with 3 beats in flight -> out_valid=0, busy=0 immediately; no stale beat after release.
